// File: rtl/levelsync_filt.sv
// -----------------------------------------------------------------------------
// levelsync_filt
//   Multi-channel level synchroniser with an optional per-channel stability
//   filter and optional edge detection. Each channel is fully independent:
//   a SYNC_STAGES-deep flop chain brings the asynchronous level into the
//   clk_dest domain. The filter (when FILT_CYCLES > 0) then only accepts a new
//   level once it has been seen for FILT_CYCLES consecutive edges.
//
//   Build option:
//     LEVELSYNC_FILT_EDGE_DET_EN  defined   -> dest_rise / dest_fall report
//                                              one-cycle pulses on dest_data
//                                              changes.
//                                 undefined -> dest_rise / dest_fall are
//                                              tied to zero; dest_data is
//                                              unaffected.
//
//   Parameters:
//     WIDTH        number of independent channels (1..64)
//     SYNC_STAGES  synchroniser depth (2..4)
//     FILT_CYCLES  stable edges needed before dest_data updates (0..255,
//                  0 = filter bypassed, dest_data is the last sync stage)
//     RESET_VALUE  per-channel reset level of sync chain, filter, history
//
//   Ports:
//     clk_dest    in   destination clock (rising edge)
//     rst_dest_n  in   asynchronous active-low reset
//     src_data    in   [WIDTH] asynchronous source levels
//     dest_data   out  [WIDTH] synchronised, filtered levels
//     dest_rise   out  [WIDTH] one-cycle pulse on 0->1 of dest_data
//     dest_fall   out  [WIDTH] one-cycle pulse on 1->0 of dest_data
// -----------------------------------------------------------------------------
module levelsync_filt #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk_dest,
  input  logic             rst_dest_n,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] dest_data,
  output logic [WIDTH-1:0] dest_rise,
  output logic [WIDTH-1:0] dest_fall
);

  // ---------------------------------------------------------------------------
  // Parameter legality: refuse to elaborate out-of-range configurations.
  // ---------------------------------------------------------------------------
  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("levelsync_filt: WIDTH must be in 1..64");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("levelsync_filt: SYNC_STAGES must be in 2..4");
    end
    if (FILT_CYCLES < 0 || FILT_CYCLES > 255) begin : g_bad_filt
      $error("levelsync_filt: FILT_CYCLES must be in 0..255");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Synchroniser chain. r_meta is the flop that samples the asynchronous
  // input and may go metastable; r_sync holds the remaining resolution stages.
  // Every bit is a separate chain, nothing crosses between channels.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES-1];
  logic [WIDTH-1:0] w_sync_out;

  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      r_meta <= RESET_VALUE;
      for (int s = 0; s < SYNC_STAGES - 1; s++) begin
        r_sync[s] <= RESET_VALUE;
      end
    end else begin
      r_meta    <= src_data;
      r_sync[0] <= r_meta;
      for (int s = 1; s < SYNC_STAGES - 1; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-2];

  // ---------------------------------------------------------------------------
  // Stability filter.
  // ---------------------------------------------------------------------------
  generate
    if (FILT_CYCLES == 0) begin : g_bypass
      assign dest_data = w_sync_out;
    end else begin : g_filter
      // Terminal count: the N-th consecutive differing sample commits.
      localparam logic [7:0] CNT_LAST = 8'(FILT_CYCLES - 1);

      logic [7:0]       r_cnt [WIDTH];
      logic [WIDTH-1:0] r_dest;

      // A sample equal to the current output clears the count, so short
      // excursions never accumulate across glitches. The count stops at
      // CNT_LAST because reaching it always commits and clears.
      always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
          r_dest <= RESET_VALUE;
          for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= 8'd0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_sync_out[i] == r_dest[i]) begin
              r_cnt[i] <= 8'd0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_dest[i] <= w_sync_out[i];
              r_cnt[i]  <= 8'd0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 8'd1;
            end
          end
        end
      end

      assign dest_data = r_dest;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detection on dest_data.
  // ---------------------------------------------------------------------------
`ifdef LEVELSYNC_FILT_EDGE_DET_EN
  logic [WIDTH-1:0] r_prev;

  // r_prev resets to RESET_VALUE, the same level dest_data resets to, so no
  // spurious pulse appears on the first edges after reset release.
  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      r_prev <= RESET_VALUE;
    end else begin
      r_prev <= dest_data;
    end
  end

  // Gated by reset so the pulses are zero while reset is held.
  assign dest_rise = rst_dest_n ? (dest_data & ~r_prev) : {WIDTH{1'b0}};
  assign dest_fall = rst_dest_n ? (~dest_data & r_prev) : {WIDTH{1'b0}};
`else
  assign dest_rise = {WIDTH{1'b0}};
  assign dest_fall = {WIDTH{1'b0}};
`endif

endmodule
